// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Size codes, FSM states and latency limits.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsuState_t;

  function automatic logic [31:0] sizeMask(
    input logic [1:0] sz
  );
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    unique case (1'b1)
      sz == SZ_BYTE: m = 32'h0000_00FF;
      sz == SZ_HALF: m = 32'h0000_FFFF;
      default:       m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_load_extend.sv
// Right-justified load data to 32-bit result.
// Sign or zero extension for byte and halfword.
module mips_load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] ReadData,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] extData
);

  logic sgnB;
  logic sgnH;

  assign sgnB = ~load_unsigned & ReadData[7];
  assign sgnH = ~load_unsigned & ReadData[15];

  always_comb begin
    extData = ReadData;
    unique case (1'b1)
      size == SZ_BYTE:
        extData = {{24{sgnB}}, ReadData[7:0]};
      size == SZ_HALF:
        extData = {{16{sgnH}}, ReadData[15:0]};
      default:
        extData = ReadData;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MEM-stage load/store unit: one access per handshake,
// fixed memory latency, single-cycle response pulse.
module mips_lsu
  import mips_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ByteEnable,
  output logic        HalfwordEnable,
  output logic        WordEnable,
  input  logic [31:0] ReadData
);

  if (MEM_LATENCY < MEM_LAT_MIN ||
      MEM_LATENCY > MEM_LAT_MAX) begin : gBadLat
    $error("mips_lsu: MEM_LATENCY out of range");
  end

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  lsuState_t   state;
  lsuState_t   stateNext;
  logic [31:0] addrQ;
  logic [31:0] dataQ;
  logic [1:0]  sizeQ;
  logic        unsQ;
  logic        loadQ;
  logic        storeQ;
  logic [3:0]  cnt;
  logic [31:0] loadDataQ;
  logic        faultQ;
  logic [31:0] extData;
  logic        reqFault;
  logic        reqNop;

  mips_load_extend uExt (
    .ReadData      (ReadData),
    .size          (sizeQ),
    .load_unsigned (unsQ),
    .extData       (extData)
  );

  assign reqFault = (size == SZ_ILLEGAL) ||
                    (is_load && is_store) ||
                    (size == SZ_HALF && addr[0]) ||
                    (size == SZ_WORD && addr[1:0] != 2'b00);
  assign reqNop   = !is_load && !is_store;

  assign load_data = loadDataQ;
  assign fault     = faultQ;

  always_comb begin
    stateNext      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    Address        = '0;
    WriteData      = '0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    ByteEnable     = 1'b0;
    HalfwordEnable = 1'b0;
    WordEnable     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          stateNext = (reqFault || reqNop) ? RESP : ACCESS;
      end
      ACCESS: begin
        Address        = addrQ;
        MemRead        = loadQ;
        MemWrite       = storeQ;
        ByteEnable     = sizeQ == SZ_BYTE;
        HalfwordEnable = sizeQ == SZ_HALF;
        WordEnable     = sizeQ == SZ_WORD;
        if (storeQ)
          WriteData = dataQ & sizeMask(sizeQ);
        if (cnt == 4'd0)
          stateNext = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addrQ     <= '0;
      dataQ     <= '0;
      sizeQ     <= SZ_BYTE;
      unsQ      <= 1'b0;
      loadQ     <= 1'b0;
      storeQ    <= 1'b0;
      cnt       <= '0;
      loadDataQ <= '0;
      faultQ    <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req_valid) begin
        addrQ  <= addr;
        dataQ  <= store_data;
        sizeQ  <= size;
        unsQ   <= load_unsigned;
        loadQ  <= is_load;
        storeQ <= is_store;
        cnt    <= CNT_INIT;
        // Faults and no-ops skip ACCESS, so publish their result now.
        if (reqFault || reqNop) begin
          faultQ    <= reqFault;
          loadDataQ <= '0;
        end
      end
      if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) begin
          faultQ    <= 1'b0;
          loadDataQ <= loadQ ? extData : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu with a byte-array memory
// and a spec-level reference model of loads and stores.
module tb_mips_lsu;
  import mips_mem_pkg::*;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        fault;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        ByteEnable;
  logic        HalfwordEnable;
  logic        WordEnable;
  logic [31:0] ReadData;

  mips_lsu #(.MEM_LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .is_load        (is_load),
    .is_store       (is_store),
    .size           (size),
    .load_unsigned  (load_unsigned),
    .addr           (addr),
    .store_data     (store_data),
    .resp_valid     (resp_valid),
    .load_data      (load_data),
    .fault          (fault),
    .Address        (Address),
    .WriteData      (WriteData),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .ByteEnable     (ByteEnable),
    .HalfwordEnable (HalfwordEnable),
    .WordEnable     (WordEnable),
    .ReadData       (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory seen by the DUT and the model's own copy.
  bit [7:0] dmem [512];
  bit [7:0] rmem [512];

  always @(posedge clk) begin
    if (MemWrite) begin
      dmem[Address[8:0]] <= WriteData[7:0];
      if (HalfwordEnable || WordEnable)
        dmem[9'(Address[8:0] + 9'd1)] <= WriteData[15:8];
      if (WordEnable) begin
        dmem[9'(Address[8:0] + 9'd2)] <= WriteData[23:16];
        dmem[9'(Address[8:0] + 9'd3)] <= WriteData[31:24];
      end
    end
  end

  always @* begin
    ReadData = '0;
    if (MemRead) begin
      ReadData[7:0] = dmem[Address[8:0]];
      if (HalfwordEnable || WordEnable)
        ReadData[15:8] = dmem[9'(Address[8:0] + 9'd1)];
      if (WordEnable) begin
        ReadData[23:16] = dmem[9'(Address[8:0] + 9'd2)];
        ReadData[31:24] = dmem[9'(Address[8:0] + 9'd3)];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        flt;
    int          cyc;
  } exp_t;

  exp_t expQ [$];
  exp_t mon;

  int nChk  = 0;
  int nFail = 0;

  logic [1:0]  curSize;
  logic        curLd;
  logic        curSt;
  logic        curNoAcc;
  logic [31:0] curAddr;
  logic [31:0] curData;

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    nChk++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, want, cyc);
    end
  endfunction

  function automatic logic [2:0] enExp(input logic [1:0] sz);
    if (sz == 2'd0) return 3'b100;
    if (sz == 2'd1) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [31:0] maskExp(input logic [1:0] sz);
    if (sz == 2'd0) return 32'hFF;
    if (sz == 2'd1) return 32'hFFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic isBad(
    input logic ld, input logic st,
    input logic [1:0] sz, input logic [31:0] a
  );
    return (sz == 2'd3) || (ld && st) ||
           (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0);
  endfunction

  // Little-endian byte memory; loads extend by value range.
  task automatic model(
    input  logic        ld,
    input  logic        st,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic        flt,
    output logic [31:0] res
  );
    int nb;
    logic [31:0] v;
    flt = isBad(ld, st, sz, a);
    res = '0;
    if (flt || (!ld && !st)) return;
    nb = 1 << sz;
    if (st) begin
      for (int i = 0; i < nb; i++)
        rmem[(a + i) % 512] = 8'(d >> (8 * i));
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++)
        v = v + (32'(rmem[(a + i) % 512]) << (8 * i));
      if (!uns && nb < 4 && v >= (32'd1 << (8 * nb - 1)))
        v = v - (32'd1 << (8 * nb));
      res = v;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (expQ.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon = expQ.pop_front();
          chk("load_data", load_data, mon.data);
          chk("fault", 32'(fault), 32'(mon.flt));
          chk("resp_cycle", cyc, mon.cyc);
        end
      end
      if (MemRead || MemWrite) begin
        chk("strobe_no_access", 32'(curNoAcc), 32'd0);
        chk("mem_addr", Address, curAddr);
        chk("mem_read", 32'(MemRead), 32'(curLd));
        chk("mem_write", 32'(MemWrite), 32'(curSt));
        chk("enables",
            32'({ByteEnable, HalfwordEnable, WordEnable}),
            32'(enExp(curSize)));
        chk("write_data", WriteData,
            curSt ? (curData & maskExp(curSize)) : 32'd0);
      end
    end
  end

  task automatic setCur(
    input logic ld, input logic st, input logic [1:0] sz,
    input logic [31:0] a, input logic [31:0] d
  );
    curLd    = ld;
    curSt    = st;
    curSize  = sz;
    curAddr  = a;
    curData  = d;
    curNoAcc = isBad(ld, st, sz, a) || (!ld && !st);
  endtask

  task automatic issue(
    input logic        ld,
    input logic        st,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [31:0] a,
    input logic [31:0] d,
    input bit          track
  );
    int n;
    logic f;
    logic [31:0] r;
    exp_t e;
    @(posedge clk);
    #1;
    req_valid     = 1'b1;
    is_load       = ld;
    is_store      = st;
    size          = sz;
    load_unsigned = uns;
    addr          = a;
    store_data    = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    setCur(ld, st, sz, a, d);
    if (track) begin
      model(ld, st, sz, uns, a, d, f, r);
      e.data = r;
      e.flt  = f;
      e.cyc  = cyc + 1 + (curNoAcc ? 0 : LAT);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0)
      chk("drain_timeout", 32'(expQ.size()), 32'd0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lastAcc;
    int nAcc;
    logic f;
    logic [31:0] r;
    exp_t e;
    logic [1:0] sz;
    logic [31:0] a;
    int op;

    reset         = 1'b1;
    req_valid     = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    size          = 2'd0;
    load_unsigned = 1'b0;
    addr          = '0;
    store_data    = '0;
    setCur(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_address", Address, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_strobes",
        32'({MemRead, MemWrite, ByteEnable,
             HalfwordEnable, WordEnable}), 32'd0);
    reset = 1'b0;

    // word store/load
    issue(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 1);
    issue(1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1);
    // byte
    issue(0, 1, SZ_BYTE, 0, 32'h20, 32'h80, 1);
    issue(1, 0, SZ_BYTE, 0, 32'h20, 32'h0, 1);
    issue(1, 0, SZ_BYTE, 1, 32'h20, 32'h0, 1);
    // halfword and partial overwrite
    issue(0, 1, SZ_HALF, 0, 32'h24, 32'h8001, 1);
    issue(1, 0, SZ_HALF, 0, 32'h24, 32'h0, 1);
    issue(1, 0, SZ_HALF, 1, 32'h24, 32'h0, 1);
    issue(0, 1, SZ_BYTE, 0, 32'h24, 32'hFFFF_FF34, 1);
    issue(1, 0, SZ_HALF, 1, 32'h24, 32'h0, 1);
    // faults, then confirm memory untouched
    issue(1, 0, SZ_WORD, 0, 32'h22, 32'h0, 1);
    issue(0, 1, SZ_HALF, 0, 32'h25, 32'h1234, 1);
    issue(1, 0, SZ_ILLEGAL, 0, 32'h0, 32'h0, 1);
    issue(1, 1, SZ_WORD, 0, 32'h10, 32'h0, 1);
    issue(1, 0, SZ_WORD, 0, 32'h24, 32'h0, 1);
    // no-op
    issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 1);
    drain();

    // back-to-back requests with req_valid held high
    @(posedge clk);
    #1;
    req_valid     = 1'b1;
    is_load       = 1'b1;
    is_store      = 1'b0;
    size          = SZ_WORD;
    load_unsigned = 1'b0;
    addr          = 32'h10;
    store_data    = '0;
    setCur(1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
    model(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, f, r);
    lastAcc = -1;
    nAcc    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.data = r;
        e.flt  = f;
        e.cyc  = cyc + 1 + LAT;
        expQ.push_back(e);
        if (lastAcc >= 0)
          chk("accept_spacing", cyc - lastAcc, LAT + 2);
        lastAcc = cyc;
        nAcc++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("stream_accepts", nAcc, 4);
    drain();

    // reset in the second ACCESS cycle of a store
    issue(0, 1, SZ_WORD, 0, 32'h40, 32'h12345678, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_load_data", load_data, 32'd0);
    chk("abort_fault", 32'(fault), 32'd0);
    chk("abort_address", Address, 32'd0);
    chk("abort_wdata", WriteData, 32'd0);
    chk("abort_strobes",
        32'({MemRead, ByteEnable, HalfwordEnable, WordEnable}),
        32'd0);
    reset = 1'b0;
    repeat (2 * LAT + 4) @(posedge clk);

    // randomized traffic away from the aborted word
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      a  = 32'($urandom_range(0, 511));
      if (a >= 32'h40 && a < 32'h44) a = a + 32'h80;
      if ($urandom_range(0, 4) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      issue(op < 4, op >= 4 && op < 8 || op == 8,
            sz, 1'($urandom_range(0, 1)), a, $urandom, 1);
    end
    drain();
    chk("queue_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- MEM-stage load/store unit between the pipeline and the byte-addressable data memory. It drives the memory's Address/WriteData/MemRead/MemWrite and the Byte/Halfword/Word enables, and consumes ReadData.
- Accepts one access per valid/ready handshake, checks size/alignment, and sign- or zero-extends load results.
- Returns the result with a single-cycle resp_valid pulse after a fixed, parameterised memory latency.

Parameters:
- MEM_LATENCY, 1: number of cycles Address/strobes are held before ReadData is sampled or the store is considered complete; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the clk rising edge.
- req_valid  input  1  pipeline request present.
- req_ready  output  1  unit idle; request accepted when req_valid && req_ready.
- is_load  input  1  load request.
- is_store  input  1  store request.
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- load_unsigned  input  1  zero-extend (lbu/lhu) when 1, sign-extend when 0.
- addr  input  32  byte address.
- store_data  input  32  store operand, right-justified.
- resp_valid  output  1  one-cycle pulse: load_data/fault valid.
- load_data  output  32  extended load result; 0 for stores, faults and no-ops.
- fault  output  1  misaligned address or illegal request.
- Address  output  32  to data memory.
- WriteData  output  32  to data memory.
- MemRead  output  1  to data memory.
- MemWrite  output  1  to data memory.
- ByteEnable  output  1  to data memory.
- HalfwordEnable  output  1  to data memory.
- WordEnable  output  1  to data memory.
- ReadData  input  32  from data memory; the selected byte/half is right-justified.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; load_data=0; fault=0; Address=0; WriteData=0; all memory strobes and enables 0.
- FSM states: IDLE, ACCESS, RESP. req_ready=1 only in IDLE.
- IDLE, on accept, latch addr, store_data, size, load_unsigned and the op, then:
  - size==11, or is_load&&is_store, or half with addr[0]!=0, or word with addr[1:0]!=0 → RESP with fault=1. No memory strobe is ever asserted.
  - is_load==is_store==0 → RESP as a no-op: fault=0, load_data=0.
  - Otherwise → ACCESS with the latency counter loaded to MEM_LATENCY-1.
- ACCESS:
  - Address = latched addr.
  - Exactly one enable asserted, matching size.
  - Load: MemRead=1.
  - Store: MemWrite=1 and WriteData = store_data masked to size (upper bits zero).
  - The counter decrements each cycle. In the cycle the counter is 0, ReadData is sampled and extended into the load_data register, then the FSM goes to RESP.
  - Strobes are deasserted and Address/WriteData return to 0 on leaving ACCESS.
- RESP: resp_valid=1 for exactly one cycle, fault/load_data valid, then IDLE. load_data and fault hold until the next RESP.
- Latency: for accept at edge N, ACCESS covers cycles N+1..N+MEM_LATENCY and resp_valid is high in cycle N+MEM_LATENCY+1. Fault/no-op: resp_valid in cycle N+1. Maximum throughput is one access per MEM_LATENCY+2 cycles.
- Extension:
  - Byte: {{24{b[7]}},b[7:0]} when signed, {24'b0,b[7:0]} when unsigned.
  - Half: same pattern with bit 15.
  - Word: load_unsigned is ignored.
- req_valid while busy is ignored (not consumed); inputs outside the accept cycle are don't-care.
- Reset mid-operation: after the edge the FSM is IDLE and all strobes are 0. A pending resp_valid is dropped. An in-flight store is aborted; memory contents are then undefined for that address.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL;
  - FSM state encoding;
  - the MEM_LATENCY range limits.
- Sub-module mips_load_extend: combinational; inputs ReadData, size and load_unsigned; output is the extended 32-bit value. Also used for lb/lh/lbu/lhu unit tests.

Test Plan:
1. Reset, then sw 0xDEADBEEF @0x10, then lw @0x10 → load_data=0xDEADBEEF, fault=0. resp_valid exactly MEM_LATENCY+1 cycles after accept. WordEnable is the only enable high during ACCESS.
2. sb 0x80 @0x20; lb @0x20 → 0xFFFFFF80; lbu @0x20 → 0x00000080. During the sb, WriteData=0x00000080.
3. sh 0x8001 @0x24; lh → 0xFFFF8001; lhu → 0x00008001. Overwrite with sb 0x34 @0x24, then lhu → 0x00008034.
4. lw @0x22, sh @0x25 and size=11 @0x0 → each gives fault=1 and resp_valid one cycle after accept. MemRead/MemWrite stay 0 throughout. A following lw @0x24 confirms memory is unchanged.
5. req_valid held high for 20 cycles with MEM_LATENCY=3 → accepts spaced exactly 5 cycles apart, one resp_valid per accept, req_ready low while busy.
6. Assert reset in the second ACCESS cycle of a store (MEM_LATENCY=3) → the next cycle has MemWrite=0, req_ready=1, resp_valid never pulses for that request, and all outputs are at reset values.
